// File: rtl/log_ram_reader_if.sv
// Handshake bundle between log_ram_reader, the log RAM read port and the word consumer.
// The master modport is the reader; the slave modport is the RAM/consumer/control side.
interface log_ram_reader_if #(
   parameter int NB_DATA = 8,
   parameter int NB_ADDR = 4
);
   logic               i_ram_full;
   logic               i_start;
   logic               o_ram_rd_en;
   logic [NB_ADDR-1:0] o_ram_rd_addr;
   logic [NB_DATA-1:0] i_ram_rd_data;
   logic [NB_DATA-1:0] o_data;
   logic               o_valid;
   logic               i_ready;
   logic               o_busy;
   logic               o_done;
   logic               o_clear_log;

   modport master (
      input  i_ram_full, i_start, i_ram_rd_data, i_ready,
      output o_ram_rd_en, o_ram_rd_addr, o_data, o_valid, o_busy, o_done, o_clear_log
   );

   modport slave (
      output i_ram_full, i_start, i_ram_rd_data, i_ready,
      input  o_ram_rd_en, o_ram_rd_addr, o_data, o_valid, o_busy, o_done, o_clear_log
   );
endinterface

// File: rtl/log_ram_reader.sv
// Drains a full log RAM word by word onto a valid/ready stream, then re-arms the log writer.
// Optional running checksum of delivered words when LOG_RAM_READER_CHECKSUM_EN is defined.
module log_ram_reader #(
   parameter int NB_DATA = 8,
   parameter int NB_ADDR = 4
) (
   input  logic               clock,
   input  logic               i_reset,
   log_ram_reader_if.master   bus
`ifdef LOG_RAM_READER_CHECKSUM_EN
   ,
   output logic [NB_DATA-1:0] o_checksum
`endif
);

   localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_DATA,
      HOLD,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [NB_ADDR-1:0] addr;
   logic [NB_DATA-1:0] data_q;
   logic               launch;
   logic               xfer;

   // A readout only starts from IDLE with a full RAM; start requests anywhere else are dropped.
   assign launch = (state == IDLE) && bus.i_start && bus.i_ram_full;
   assign xfer   = (state == HOLD) && bus.i_ready;

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (launch) state_nxt = FETCH;
         FETCH:     state_nxt = WAIT_DATA;
         WAIT_DATA: state_nxt = HOLD;
         HOLD: begin
            if (xfer) begin
               state_nxt = (addr == LAST_ADDR) ? DONE : FETCH;
            end
         end
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Address stays on the last word after the final transfer rather than wrapping.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         addr <= '0;
      end else if (launch) begin
         addr <= '0;
      end else if (xfer && (addr != LAST_ADDR)) begin
         addr <= addr + NB_ADDR'(1);
      end
   end

   // RAM returns data one cycle after the strobe, which is the WAIT_DATA cycle.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         data_q <= '0;
      end else if (state == WAIT_DATA) begin
         data_q <= bus.i_ram_rd_data;
      end
   end

   assign bus.o_ram_rd_en   = (state == FETCH);
   assign bus.o_ram_rd_addr = addr;
   assign bus.o_data        = data_q;
   assign bus.o_valid       = (state == HOLD);
   assign bus.o_busy        = (state != IDLE);
   assign bus.o_done        = (state == DONE);
   assign bus.o_clear_log   = (state == DONE);

`ifdef LOG_RAM_READER_CHECKSUM_EN
   logic [NB_DATA-1:0] checksum_q;

   function automatic logic [NB_DATA-1:0] wrap_add(input logic [NB_DATA-1:0] a,
                                                   input logic [NB_DATA-1:0] b);
      return a + b;
   endfunction

   // Cleared when a readout launches, so the value holds from DONE until the next start.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         checksum_q <= '0;
      end else if (launch) begin
         checksum_q <= '0;
      end else if (xfer) begin
         checksum_q <= wrap_add(checksum_q, data_q);
      end
   end

   assign o_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_log_ram_reader.sv
// Randomized self-checking bench for log_ram_reader against a queue-based reference model.
module tb_log_ram_reader;
   localparam int NB_DATA = 8;
   localparam int NB_ADDR = 4;
   localparam int DEPTH   = 1 << NB_ADDR;

   logic clock;
   logic i_reset;
   log_ram_reader_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();
`ifdef LOG_RAM_READER_CHECKSUM_EN
   logic [NB_DATA-1:0] o_checksum;
`endif

   log_ram_reader #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .bus     (bus)
`ifdef LOG_RAM_READER_CHECKSUM_EN
      ,
      .o_checksum (o_checksum)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   logic [NB_DATA-1:0] ram [DEPTH];
   logic [NB_DATA-1:0] got [$];
   int                 addrs [$];
   int                 done_cnt, clr_mis, stab_err, rden_cnt, busy_cnt;
   logic               prev_hold;
   logic [NB_DATA-1:0] prev_data;

   always @(posedge clock)
      bus.i_ram_rd_data <= bus.o_ram_rd_en ? ram[bus.o_ram_rd_addr] : 8'hA5;

   always @(negedge clock) begin
      if (bus.o_valid && bus.i_ready) got.push_back(bus.o_data);
      if (bus.o_ram_rd_en) begin
         addrs.push_back(int'(bus.o_ram_rd_addr));
         rden_cnt++;
      end
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) done_cnt++;
      if (bus.o_done !== bus.o_clear_log) clr_mis++;
      if (prev_hold && bus.o_valid && (bus.o_data !== prev_data)) stab_err++;
      prev_hold = bus.o_valid && !bus.i_ready;
      prev_data = bus.o_data;
   end

   function automatic logic [NB_DATA-1:0] model_sum();
      int s = 0;
      for (int i = 0; i < DEPTH; i++) s += int'(ram[i]);
      return NB_DATA'(s % 256);
   endfunction

   task automatic clear_monitor();
      got.delete();
      addrs.delete();
      done_cnt = 0; clr_mis = 0; stab_err = 0; rden_cnt = 0; busy_cnt = 0;
      prev_hold = 1'b0;
   endtask

   // mode 0: ready always high, 1: one-on/two-off, 2: random ready
   task automatic run_readout(input int mode, input int restart_at, input int drop_at,
                              output int cyc, output bit timed_out);
      bit did = 0;
      clear_monitor();
      @(posedge clock); #1 bus.i_start = 1'b1;
      @(posedge clock); #1 bus.i_start = 1'b0;
      cyc = 0;
      timed_out = 1'b1;
      while (cyc < 800) begin
         @(negedge clock);
         if (bus.o_done) begin
            timed_out = 1'b0;
            break;
         end
         @(posedge clock);
         cyc++;
         #1;
         case (mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = (cyc % 3 == 0);
            default: bus.i_ready = 1'($urandom_range(0, 1));
         endcase
         bus.i_start = 1'b0;
         if (!did && got.size() == restart_at) begin
            bus.i_start = 1'b1;
            did = 1;
         end
         if (drop_at >= 0 && got.size() >= drop_at) bus.i_ram_full = 1'b0;
      end
      if (timed_out) $display("FAIL readout_timeout: no o_done within %0d cycles", cyc);
      repeat (3) @(posedge clock);
      #1 bus.i_ready = 1'b1;
      bus.i_ram_full = 1'b1;
      bus.i_start = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b0;
      #3;
      n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.o_busy); else n_pass++;
      n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.o_valid); else n_pass++;
      n_checks++; if (bus.o_data !== '0) $display("FAIL rst_data: got %h want 00", bus.o_data); else n_pass++;
      n_checks++; if (bus.o_ram_rd_en !== 1'b0) $display("FAIL rst_rden: got %b want 0", bus.o_ram_rd_en); else n_pass++;
      n_checks++; if (bus.o_ram_rd_addr !== '0) $display("FAIL rst_addr: got %h want 0", bus.o_ram_rd_addr); else n_pass++;
      n_checks++; if ({bus.o_done, bus.o_clear_log} !== 2'b00) $display("FAIL rst_done: got %b want 00", {bus.o_done, bus.o_clear_log}); else n_pass++;
`ifdef LOG_RAM_READER_CHECKSUM_EN
      n_checks++; if (o_checksum !== '0) $display("FAIL rst_checksum: got %h want 00", o_checksum); else n_pass++;
`endif
      repeat (2) @(posedge clock);
      #1 i_reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rst_idle_after_release: busy %b want 0", bus.o_busy); else n_pass++;
   endtask

   task automatic test_ready_pattern(input string tag, input int mode);
      int cyc; bit to; int bad;
      run_readout(mode, -1, -1, cyc, to);
      n_checks++; if (to) $display("FAIL %s_done: timed out", tag); else n_pass++;
      if (mode == 0) begin
         n_checks++; if (cyc !== 3 * DEPTH) $display("FAIL %s_latency: got %0d want %0d", tag, cyc, 3 * DEPTH); else n_pass++;
      end
      n_checks++; if (got.size() !== DEPTH) $display("FAIL %s_count: got %0d want %0d", tag, got.size(), DEPTH); else n_pass++;
      bad = 0;
      for (int i = 0; i < got.size() && i < DEPTH; i++) if (got[i] !== ram[i]) bad++;
      n_checks++; if (bad !== 0) $display("FAIL %s_words: %0d wrong words, first got %h want %h", tag, bad, got.size() ? got[0] : 8'h00, ram[0]); else n_pass++;
      bad = 0;
      for (int i = 0; i < addrs.size(); i++) if (addrs[i] !== i) bad++;
      n_checks++; if (bad !== 0 || addrs.size() !== DEPTH) $display("FAIL %s_addrs: %0d bad of %0d fetches want %0d", tag, bad, addrs.size(), DEPTH); else n_pass++;
      n_checks++; if (done_cnt !== 1) $display("FAIL %s_done_pulses: got %0d want 1", tag, done_cnt); else n_pass++;
      n_checks++; if (clr_mis !== 0) $display("FAIL %s_clear_log: %0d cycles differ from o_done want 0", tag, clr_mis); else n_pass++;
      n_checks++; if (stab_err !== 0) $display("FAIL %s_stable: %0d changes while stalled want 0", tag, stab_err); else n_pass++;
      n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL %s_idle: busy %b want 0", tag, bus.o_busy); else n_pass++;
`ifdef LOG_RAM_READER_CHECKSUM_EN
      n_checks++; if (o_checksum !== model_sum()) $display("FAIL %s_checksum: got %h want %h", tag, o_checksum, model_sum()); else n_pass++;
`endif
   endtask

   task automatic test_not_full();
      clear_monitor();
      @(posedge clock); #1 bus.i_ram_full = 1'b0; bus.i_start = 1'b1;
      @(posedge clock); #1 bus.i_start = 1'b0;
      repeat (10) @(posedge clock);
      #1 bus.i_ram_full = 1'b1;
      n_checks++; if (busy_cnt !== 0) $display("FAIL notfull_busy: busy for %0d cycles want 0", busy_cnt); else n_pass++;
      n_checks++; if (rden_cnt !== 0) $display("FAIL notfull_rden: %0d strobes want 0", rden_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n = 0; int bad = 0;
      clear_monitor();
      @(posedge clock); #1 bus.i_ready = 1'b1; bus.i_start = 1'b1;
      @(posedge clock); #1 bus.i_start = 1'b0;
      while (got.size() < 7 && n < 200) begin
         @(posedge clock);
         n++;
      end
      n_checks++; if (got.size() < 7) $display("FAIL rstmid_reach: got %0d words want 7", got.size()); else n_pass++;
      #3 i_reset = 1'b0;
      #1;
      n_checks++; if ({bus.o_busy, bus.o_valid, bus.o_ram_rd_en, bus.o_done, bus.o_clear_log} !== 5'b0) $display("FAIL rstmid_ctrl: got %b want 00000", {bus.o_busy, bus.o_valid, bus.o_ram_rd_en, bus.o_done, bus.o_clear_log}); else n_pass++;
      n_checks++; if (bus.o_data !== '0 || bus.o_ram_rd_addr !== '0) $display("FAIL rstmid_data: data %h addr %h want 0", bus.o_data, bus.o_ram_rd_addr); else n_pass++;
      @(posedge clock); #1 i_reset = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      n_checks++; if (done_cnt !== 0) $display("FAIL rstmid_no_done: %0d pulses want 0", done_cnt); else n_pass++;
      n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rstmid_waits_idle: busy %b want 0", bus.o_busy); else n_pass++;
      test_ready_pattern("after_reset", 0);
   endtask

   task automatic test_restart_ignored();
      int cyc; bit to; int bad = 0;
      run_readout(0, 4, 5, cyc, to);
      n_checks++; if (to) $display("FAIL restart_done: timed out"); else n_pass++;
      n_checks++; if (got.size() !== DEPTH) $display("FAIL restart_count: got %0d want %0d", got.size(), DEPTH); else n_pass++;
      for (int i = 0; i < got.size() && i < DEPTH; i++) if (got[i] !== ram[i]) bad++;
      n_checks++; if (bad !== 0) $display("FAIL restart_words: %0d wrong want 0", bad); else n_pass++;
      n_checks++; if (done_cnt !== 1) $display("FAIL restart_done_pulses: got %0d want 1", done_cnt); else n_pass++;
      n_checks++; if (cyc !== 3 * DEPTH) $display("FAIL restart_latency: got %0d want %0d", cyc, 3 * DEPTH); else n_pass++;
   endtask

   initial begin
      i_reset = 1'b0;
      bus.i_ram_full = 1'b1;
      bus.i_start = 1'b0;
      bus.i_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) ram[i] = NB_DATA'(i * 3);
      test_reset();
      test_ready_pattern("ready_high", 0);
`ifdef LOG_RAM_READER_CHECKSUM_EN
      n_checks++; if (o_checksum !== 8'h68) $display("FAIL checksum_addr3: got %h want 68", o_checksum); else n_pass++;
`endif
      test_ready_pattern("ready_1on2off", 1);
      test_not_full();
      test_reset_mid();
      test_restart_ignored();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < DEPTH; i++) ram[i] = NB_DATA'($urandom);
         test_ready_pattern("random", 2);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/log_ram_reader.md
LOG_RAM_READER -- requirements
Module: log_ram_reader

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: log word width.
REQ-002 SHALL have parameter NB_ADDR, default 4: log RAM address width; depth = 2^NB_ADDR.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ram_full  input  1  log RAM full flag from the log writer.
REQ-006 SHALL have port i_start  input  1  readout request, sampled per cycle.
REQ-007 SHALL have port o_ram_rd_en  output  1  RAM read strobe.
REQ-008 SHALL have port o_ram_rd_addr  output  NB_ADDR  RAM read address.
REQ-009 SHALL have port i_ram_rd_data  input  NB_DATA  RAM read data, valid exactly 1 cycle after o_ram_rd_en.
REQ-010 SHALL have port o_data  output  NB_DATA  log word to consumer.
REQ-011 SHALL have port o_valid  output  1  o_data valid.
REQ-012 SHALL have port i_ready  input  1  consumer accepts o_data.
REQ-013 SHALL have port o_busy  output  1  readout in progress.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse, readout complete.
REQ-015 SHALL have port o_clear_log  output  1  one-cycle pulse re-arming the log writer; coincident with o_done.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT_DATA, HOLD, DONE.
REQ-017 IDLE -> FETCH when i_start=1 and i_ram_full=1; address counter loaded with 0; i_start with i_ram_full=0 SHALL be ignored.
REQ-018 FETCH: o_ram_rd_en=1 for exactly one cycle at current address; next state WAIT_DATA.
REQ-019 WAIT_DATA: capture i_ram_rd_data into o_data register; next state HOLD.
REQ-020 HOLD: o_valid=1; o_data SHALL stay stable until i_ready=1 (valid/ready transfer).
REQ-021 On transfer in HOLD with address < 2^NB_ADDR-1: address +1, next state FETCH; with address = 2^NB_ADDR-1: next state DONE, address not wrapped past last word.
REQ-022 DONE: o_done=1 and o_clear_log=1 for one cycle; next state IDLE.
REQ-023 Per-word latency from FETCH to o_valid SHALL be 2 cycles; full readout with i_ready held 1 SHALL take 3*2^NB_ADDR cycles from leaving IDLE to entering DONE.
REQ-024 o_busy SHALL be 1 in FETCH, WAIT_DATA, HOLD, DONE; 0 in IDLE.
REQ-025 i_start while o_busy=1 SHALL be ignored; i_ram_full deassertion mid-readout SHALL not abort readout.
REQ-026 o_valid SHALL be 0 outside HOLD; i_ready outside HOLD SHALL have no effect.
REQ-027 Exactly 2^NB_ADDR words, addresses 0..2^NB_ADDR-1 in ascending order, SHALL be delivered per readout; no word duplicated or dropped under any i_ready pattern.

Reset
REQ-028 i_reset=0 SHALL asynchronously force state IDLE, address 0, o_data 0, o_valid 0, o_ram_rd_en 0, o_busy 0, o_done 0, o_clear_log 0.
REQ-029 Reset asserted mid-readout SHALL abandon readout without o_done/o_clear_log; after release the block waits in IDLE for a new i_start.
REQ-030 Leaving reset SHALL be synchronous to clock; first possible FETCH is the cycle after i_start is sampled with i_reset=1.

Configuration
REQ-031 Macro LOG_RAM_READER_CHECKSUM_EN defined: additional port o_checksum output NB_DATA = modulo-2^NB_DATA sum of all transferred words, cleared on leaving IDLE, stable and valid from o_done until next readout start, reset value 0.
REQ-032 Macro undefined: port o_checksum and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 RAM preloaded with addr*3, i_ram_full=1, i_start pulse, i_ready=1 -> 16 words 0x00,0x03,...,0x2D in order, o_done pulse at cycle 48 after start, o_clear_log coincident.
REQ-034 Same, i_ready toggled 1-cycle-on/2-off -> identical word sequence, o_data stable while o_valid=1 and i_ready=0.
REQ-035 i_start with i_ram_full=0 -> o_busy stays 0, o_ram_rd_en never asserted.
REQ-036 i_reset=0 asserted at word 7 -> all outputs 0 immediately, no o_done; new i_start -> readout restarts at address 0.
REQ-037 i_start re-pulsed at word 4 and i_ram_full dropped at word 5 -> readout continues, exactly 16 words, single o_done.
REQ-038 With LOG_RAM_READER_CHECKSUM_EN, data addr*3 -> o_checksum = 0x68 at o_done (360 mod 256).
